serial_add_ctrl: RTL

Bit-serial adder/subtractor controller. It time-shares one existing full_adder1 instance across all bits of a WIDTH-bit operand pair, one bit per clock, LSB first. It latches operands on a start request, sequences the shift/carry registers, and presents a registered result with a one-cycle done pulse. It is the area-minimal alternative to the ripple-carry adder in the arithmetic datapath.

---
 rtl/serial_add_pkg.sv | 19 +
 rtl/full_adder1.sv | 13 +
 rtl/serial_add_ctrl.sv | 106 ++++++++++
 3 files changed

// File: rtl/serial_add_pkg.sv
// Shared encodings and sizing helpers for the bit-serial adder controller.
package serial_add_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    RUN  = ST_RUN,
    DONE = ST_DONE
  } state_t;

  // Bit counter width; WIDTH never drops below 2, so this is at least 1.
  function automatic int cnt_w(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/full_adder1.sv
// Single-bit full adder, the only arithmetic element of the serial adder.
module full_adder1 (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial add/subtract: one full_adder1 reused over WIDTH clocks, LSB first,
// with a registered result and a one-cycle done pulse.
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int               CNT_W = cnt_w(WIDTH);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

  state_t             state, state_nxt;
  logic [WIDTH-1:0]   a_sh, b_sh, res_sh;
  logic               carry, prev_carry;
  logic [CNT_W-1:0]   bit_cnt;
  logic               fa_s, fa_co;
  logic               accept, last_bit;

  full_adder1 u_fa (
    .a  (a_sh[0]),
    .b  (b_sh[0]),
    .ci (carry),
    .s  (fa_s),
    .co (fa_co)
  );

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    last_bit  = 1'b0;
    case (state)
      IDLE: if (start) begin
        accept    = 1'b1;
        state_nxt = RUN;
      end
      RUN: if (bit_cnt == LAST) begin
        last_bit  = 1'b1;
        state_nxt = DONE;
      end
      DONE: begin
        // back-to-back accept keeps the adder busy without an IDLE bubble
        if (start) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh       <= '0;
      b_sh       <= '0;
      res_sh     <= '0;
      carry      <= 1'b0;
      prev_carry <= 1'b0;
      bit_cnt    <= '0;
      sum        <= '0;
      cout       <= 1'b0;
    end else if (accept) begin
      // subtraction is a + ~b + 1
      a_sh    <= a;
      b_sh    <= sub ? ~b : b;
      carry   <= sub ? 1'b1 : cin;
      bit_cnt <= '0;
    end else if (state == RUN) begin
      a_sh    <= a_sh >> 1;
      b_sh    <= b_sh >> 1;
      res_sh  <= {fa_s, res_sh[WIDTH-1:1]};
      carry   <= fa_co;
      bit_cnt <= bit_cnt + CNT_W'(1);
      if (last_bit) begin
        prev_carry <= carry;
        sum        <= {fa_s, res_sh[WIDTH-1:1]};
        cout       <= fa_co;
      end
    end
  end

  // prev_carry and cout only change together on DONE entry, so this holds like a register
  assign ovf  = prev_carry ^ cout;
  assign busy = (state == RUN);
  assign done = (state == DONE);

endmodule
